// File: rtl/traffic_light_ctrl_pkg.sv
// rtl/traffic_light_ctrl_pkg.sv - state codes, lamp encodings and timing defaults for the intersection controller
package traffic_light_ctrl_pkg;

    typedef enum logic [2:0] {
        MAIN_GRN = 3'd0,
        MAIN_YEL = 3'd1,
        WALK     = 3'd2,
        SIDE_GRN = 3'd3,
        SIDE_YEL = 3'd4
    } state_t;

    // Lamp vectors are {R,Y,G}
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam int TICK_DIV_DEF = 100_000_000;
    localparam int T_GRN_DEF    = 6;
    localparam int T_EXT_DEF    = 3;
    localparam int T_YEL_DEF    = 2;
    localparam int T_WALK_DEF   = 3;

    function automatic logic [2:0] main_lamp(input state_t s);
        case (s)
            MAIN_GRN: main_lamp = GRN;
            MAIN_YEL: main_lamp = YEL;
            default:  main_lamp = RED;
        endcase
    endfunction

    function automatic logic [2:0] side_lamp(input state_t s);
        case (s)
            SIDE_GRN: side_lamp = GRN;
            SIDE_YEL: side_lamp = YEL;
            default:  side_lamp = RED;
        endcase
    endfunction

    function automatic int max2(input int a, input int b);
        max2 = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_tick_gen.sv
// rtl/traffic_light_ctrl_tick_gen.sv - prescaler producing a one-cycle tick every TICK_DIV clocks
module tick_gen
    import traffic_light_ctrl_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - Moore FSM for main/side street lamps with pedestrian walk phase and green extension
module traffic_light_ctrl
    import traffic_light_ctrl_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int T_GRN    = T_GRN_DEF,
    parameter int T_EXT    = T_EXT_DEF,
    parameter int T_YEL    = T_YEL_DEF,
    parameter int T_WALK   = T_WALK_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       walk_en,
    input  logic       sensor,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk_lamp,
    output logic [2:0] state_o
);

    localparam int MAX_D = max2(max2(T_GRN + T_EXT, T_YEL), T_WALK);
    localparam int SCW   = (MAX_D > 1) ? $clog2(MAX_D) : 1;

    state_t           r_state;
    state_t           w_next_state;
    logic [SCW-1:0]   r_sec_cnt;
    logic [SCW-1:0]   w_last;
    logic             r_ext_done;
    logic             r_walk_req;
    logic [2:0]       r_main;
    logic [2:0]       r_side;
    logic             r_walk_lamp;
    logic             w_tick;
    logic             w_is_green;
    logic             w_at_end;
    logic             w_extend;
    logic             w_advance;

    // Prescaler restarts on every phase change so each phase is a whole number of seconds
    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_advance),
        .tick (w_tick)
    );

    always_comb begin
        w_next_state = r_state;
        w_is_green   = 1'b0;
        w_last       = SCW'(T_GRN - 1);
        case (r_state)
            MAIN_GRN: begin
                w_is_green   = 1'b1;
                w_last       = r_ext_done ? SCW'(T_GRN + T_EXT - 1) : SCW'(T_GRN - 1);
                w_next_state = MAIN_YEL;
            end
            MAIN_YEL: begin
                w_last       = SCW'(T_YEL - 1);
                w_next_state = r_walk_req ? WALK : SIDE_GRN;
            end
            WALK: begin
                w_last       = SCW'(T_WALK - 1);
                w_next_state = SIDE_GRN;
            end
            SIDE_GRN: begin
                w_is_green   = 1'b1;
                w_last       = r_ext_done ? SCW'(T_GRN + T_EXT - 1) : SCW'(T_GRN - 1);
                w_next_state = SIDE_YEL;
            end
            SIDE_YEL: begin
                w_last       = SCW'(T_YEL - 1);
                w_next_state = MAIN_GRN;
            end
            default: begin
                w_next_state = MAIN_GRN;
            end
        endcase
        w_at_end  = w_tick && (r_sec_cnt == w_last);
        w_extend  = w_at_end && w_is_green && sensor && !r_ext_done;
        w_advance = w_at_end && !w_extend;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= MAIN_GRN;
            r_sec_cnt   <= '0;
            r_ext_done  <= 1'b0;
            r_walk_req  <= 1'b0;
            r_main      <= GRN;
            r_side      <= RED;
            r_walk_lamp <= 1'b0;
        end else begin
            if (walk_en) begin
                r_walk_req <= 1'b1;
            end
            if (w_advance) begin
                r_state     <= w_next_state;
                r_sec_cnt   <= '0;
                r_ext_done  <= 1'b0;
                r_main      <= main_lamp(w_next_state);
                r_side      <= side_lamp(w_next_state);
                r_walk_lamp <= (w_next_state == WALK);
                // Entering WALK consumes the request, including a press in this same cycle
                if (w_next_state == WALK) begin
                    r_walk_req <= 1'b0;
                end
            end else if (w_tick) begin
                r_sec_cnt <= r_sec_cnt + 1'b1;
                if (w_extend) begin
                    r_ext_done <= 1'b1;
                end
            end
        end
    end

    assign main_lights = r_main;
    assign side_lights = r_side;
    assign walk_lamp   = r_walk_lamp;
    assign state_o     = r_state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - directed self-checking bench for traffic_light_ctrl with TICK_DIV=4
module tb_traffic_light_ctrl;
    import traffic_light_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       walk_en = 1'b0;
    logic       sensor = 1'b0;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       walk_lamp;
    logic [2:0] state_o;

    int n_tests = 0;
    int n_fail  = 0;

    traffic_light_ctrl #(.TICK_DIV(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .walk_en     (walk_en),
        .sensor      (sensor),
        .main_lights (main_lights),
        .side_lights (side_lights),
        .walk_lamp   (walk_lamp),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        walk_en = 1'b0;
        sensor = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Cycles until state_o changes, -1 if it never does within the budget
    task automatic wait_phase(output int n);
        logic [2:0] s;
        s = state_o;
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (state_o !== s) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state_o); end
        n_tests++; if (main_lights !== 3'b001) begin n_fail++; $display("FAIL reset_main got %b exp 001", main_lights); end
        n_tests++; if (side_lights !== 3'b100) begin n_fail++; $display("FAIL reset_side got %b exp 100", side_lights); end
        n_tests++; if (walk_lamp !== 1'b0) begin n_fail++; $display("FAIL reset_walk got %b exp 0", walk_lamp); end
    endtask

    task automatic test_normal_cycle();
        logic [2:0] st [5] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd0};
        int         ln [5] = '{24, 8, 24, 8, 24};
        logic [2:0] mm [5] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b001};
        logic [2:0] ss [5] = '{3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
        int n;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (state_o !== st[i]) begin n_fail++; $display("FAIL normal_state[%0d] got %0d exp %0d", i, state_o, st[i]); end
            n_tests++; if (main_lights !== mm[i]) begin n_fail++; $display("FAIL normal_main[%0d] got %b exp %b", i, main_lights, mm[i]); end
            n_tests++; if (side_lights !== ss[i]) begin n_fail++; $display("FAIL normal_side[%0d] got %b exp %b", i, side_lights, ss[i]); end
            n_tests++; if (walk_lamp !== 1'b0) begin n_fail++; $display("FAIL normal_walk[%0d] got %b exp 0", i, walk_lamp); end
            wait_phase(n);
            n_tests++; if (n !== ln[i]) begin n_fail++; $display("FAIL normal_len[%0d] got %0d exp %0d", i, n, ln[i]); end
        end
    endtask

    task automatic test_walk();
        int n;
        do_reset();
        walk_en = 1'b1;
        @(negedge clk);
        walk_en = 1'b0;
        wait_phase(n);
        n_tests++; if (n !== 23) begin n_fail++; $display("FAIL walk_main_grn_len got %0d exp 23", n); end
        wait_phase(n);
        n_tests++; if (n !== 8) begin n_fail++; $display("FAIL walk_main_yel_len got %0d exp 8", n); end
        n_tests++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL walk_state got %0d exp 2", state_o); end
        n_tests++; if ({main_lights, side_lights, walk_lamp} !== 7'b100_100_1) begin
            n_fail++; $display("FAIL walk_lamps got %b %b %b exp 100 100 1", main_lights, side_lights, walk_lamp); end
        wait_phase(n);
        n_tests++; if (n !== 12) begin n_fail++; $display("FAIL walk_len got %0d exp 12", n); end
        n_tests++; if ({state_o, main_lights, side_lights, walk_lamp} !== {3'd3, 7'b100_001_0}) begin
            n_fail++; $display("FAIL walk_after got st=%0d %b %b %b exp 3 100 001 0", state_o, main_lights, side_lights, walk_lamp); end
        repeat (4) wait_phase(n);
        n_tests++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL walk_not_repeated got %0d exp 3", state_o); end
    endtask

    task automatic test_sensor_held();
        int ln [4] = '{36, 8, 36, 8};
        int n;
        do_reset();
        sensor = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_phase(n);
            n_tests++; if (n !== ln[i]) begin n_fail++; $display("FAIL sensor_held_len[%0d] got %0d exp %0d", i, n, ln[i]); end
        end
        sensor = 1'b0;
    endtask

    task automatic test_sensor_pulse();
        int n;
        do_reset();
        repeat (23) @(negedge clk);
        sensor = 1'b1;
        @(negedge clk);
        sensor = 1'b0;
        n_tests++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL pulse_extended_state got %0d exp 0", state_o); end
        wait_phase(n);
        n_tests++; if (n !== 12) begin n_fail++; $display("FAIL pulse_extended_rest got %0d exp 12", n); end
        do_reset();
        sensor = 1'b1;
        repeat (23) @(negedge clk);
        sensor = 1'b0;
        @(negedge clk);
        n_tests++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL pulse_missed_state got %0d exp 1", state_o); end
        sensor = 1'b1;
        wait_phase(n);
        sensor = 1'b0;
        n_tests++; if (n !== 8) begin n_fail++; $display("FAIL pulse_yellow_len got %0d exp 8", n); end
    endtask

    task automatic test_reset_mid_phase();
        int n;
        do_reset();
        repeat (32) @(negedge clk);
        n_tests++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL mid_pre_state got %0d exp 3", state_o); end
        walk_en = 1'b1;
        @(negedge clk);
        walk_en = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++; if ({state_o, main_lights, side_lights, walk_lamp} !== {3'd0, 7'b001_100_0}) begin
            n_fail++; $display("FAIL mid_reset_async got st=%0d %b %b %b exp 0 001 100 0", state_o, main_lights, side_lights, walk_lamp); end
        @(negedge clk);
        rst = 1'b0;
        wait_phase(n);
        n_tests++; if (n !== 24) begin n_fail++; $display("FAIL mid_reset_grn_len got %0d exp 24", n); end
        wait_phase(n);
        n_tests++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL mid_reset_walk_cleared got %0d exp 3", state_o); end
    endtask

    task automatic test_walk_held();
        logic [2:0] st [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
        int         ln [7] = '{24, 8, 12, 24, 8, 24, 8};
        int n;
        do_reset();
        walk_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            n_tests++; if (state_o !== st[i]) begin n_fail++; $display("FAIL held_state[%0d] got %0d exp %0d", i, state_o, st[i]); end
            wait_phase(n);
            n_tests++; if (n !== ln[i]) begin n_fail++; $display("FAIL held_len[%0d] got %0d exp %0d", i, n, ln[i]); end
        end
        n_tests++; if (state_o !== 3'd2 || walk_lamp !== 1'b1) begin
            n_fail++; $display("FAIL held_walk_repeat got st=%0d lamp=%b exp 2 1", state_o, walk_lamp); end
        walk_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal_cycle();
        test_walk();
        test_sensor_held();
        test_sensor_pulse();
        test_reset_mid_phase();
        test_walk_held();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
